// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    StArb  = 1'b0,
    StLock = 1'b1
  } arb_state_e;

  // Index width for N requesters; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: first request strictly after ptr_i, wrapping.
module rr_prio_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  input  logic            mask_en_i,
  input  logic [IdxW-1:0] owner_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [N-1:0] req_m;

  // While locked only the packet owner stays eligible.
  always_comb begin
    req_m = '0;
    for (int unsigned k = 0; k < N; k++) begin
      req_m[k] = req_i[k] & (!mask_en_i || (owner_i == IdxW'(k)));
    end
  end

  always_comb begin
    logic [IdxW-1:0] cand;
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % N);
      if (!valid_o && req_m[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one registered fifo write port among N producers.
// Define FIFO_ARB_PKTLOCK_EN to keep multi-beat packets contiguous.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned B = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_bi,
  input  logic [N*B-1:0] data_bi,
  input  logic [N-1:0]   last_bi,
  output logic [N-1:0]   ack_bo,
  input  logic           fifo_full_i,
  output logic           fifo_wr_o,
  output logic [B-1:0]   fifo_wdata_bo
);

  localparam int unsigned IdxW = clog2(N);

  logic            out_valid_q, out_valid_d;
  logic [B-1:0]    out_data_q, out_data_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  arb_state_e      state_q, state_d;

  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic [B-1:0]    win_data;
  logic            drain, load;
  logic [N-1:0]    ack;

  rr_prio_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_pick (
    .req_i     (req_bi),
    .ptr_i     (rr_ptr_q),
    .mask_en_i (state_q == StLock),
    .owner_i   (owner_q),
    .valid_o   (win_valid),
    .idx_o     (win_idx)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (win_idx == IdxW'(k)) win_data = data_bi[k*B +: B];
    end
  end

  assign drain = out_valid_q & ~fifo_full_i;
  assign load  = (!out_valid_q || drain) && win_valid;

`ifdef FIFO_ARB_PKTLOCK_EN
  logic win_last;
  assign win_last = last_bi[win_idx];
`else
  logic unused_last;
  assign unused_last = ^last_bi;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    state_d     = state_q;
    ack         = '0;
    if (drain) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = win_data;
      rr_ptr_d     = win_idx;
      ack[win_idx] = 1'b1;
`ifdef FIFO_ARB_PKTLOCK_EN
      if (state_q == StArb && !win_last) begin
        state_d = StLock;
        owner_d = win_idx;
      end else if (state_q == StLock && win_last) begin
        state_d = StArb;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= IdxW'(N - 1);
      owner_q     <= '0;
      state_q     <= StArb;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      state_q     <= state_d;
    end
  end

  assign ack_bo        = rst_i ? '0 : ack;
  assign fifo_wr_o     = out_valid_q;
  assign fifo_wdata_bo = out_data_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (N=4, B=8); expected orders follow FIFO_ARB_PKTLOCK_EN.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_bi;
  logic [31:0] data_bi;
  logic [3:0]  last_bi;
  logic [3:0]  ack_bo;
  logic        fifo_full_i;
  logic        fifo_wr_o;
  logic [7:0]  fifo_wdata_bo;

  fifo_wr_arbiter #(
    .N (4),
    .B (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_bi        (req_bi),
    .data_bi       (data_bi),
    .last_bi       (last_bi),
    .ack_bo        (ack_bo),
    .fifo_full_i   (fifo_full_i),
    .fifo_wr_o     (fifo_wr_o),
    .fifo_wdata_bo (fifo_wdata_bo)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [8:0] src[4][$];   // {last, data} per requester
  logic [7:0] exp_q[$];    // directed: exact global write order
  logic [7:0] rexp[4][$];  // random: per-requester write order
  logic       rand_mode = 1'b0;
  logic [3:0] ack_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      req_bi[k]          = (src[k].size() != 0);
      data_bi[k*8 +: 8]  = (src[k].size() != 0) ? src[k][0][7:0] : 8'h00;
      last_bi[k]         = (src[k].size() != 0) ? src[k][0][8] : 1'b0;
    end
  endtask

  // One clock: sample ack mid-cycle, then retire acked beats just after the edge.
  task automatic step();
    logic [3:0] a;
    @(negedge clk);
    a = ack_bo;
    chk("ack_onehot", {31'd0, $onehot0(a)}, 32'd1);
    ack_seen = ack_seen | a;
    @(posedge clk);
    #1;
    if (!rst_i) begin
      for (int k = 0; k < 4; k++) if (a[k] && src[k].size() != 0) void'(src[k].pop_front());
    end
    drive();
  endtask

  function automatic logic all_idle();
    logic idle;
    idle = (exp_q.size() == 0) && !fifo_wr_o;
    for (int k = 0; k < 4; k++) idle = idle && (src[k].size() == 0) && (rexp[k].size() == 0);
    return idle;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    chk(name, {31'd0, all_idle()}, 32'd1);
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src[k].push_back({l, d});
  endtask

  // Monitor: every accepted fifo write is popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && fifo_wr_o && !fifo_full_i) begin
        if (rand_mode) begin
          if (rexp[fifo_wdata_bo[7:6]].size() == 0) chk("rand_extra_write", 32'(fifo_wdata_bo), 32'hFFFF);
          else chk("rand_write_order", 32'(fifo_wdata_bo),
                   32'(rexp[fifo_wdata_bo[7:6]].pop_front()));
        end else begin
          if (exp_q.size() == 0) chk("extra_write", 32'(fifo_wdata_bo), 32'hFFFF);
          else chk("write_data", 32'(fifo_wdata_bo), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    fifo_full_i = 1'b0;
    ack_seen    = '0;
    drive();
    step();
    step();
    chk("rst_wr", {31'd0, fifo_wr_o}, 32'd0);
    chk("rst_wdata", 32'(fifo_wdata_bo), 32'd0);
    chk("rst_ack", 32'(ack_bo), 32'd0);
    rst_i = 1'b0;
    step();

    // All four requesting: strict rotation starting at requester 0.
    for (int k = 0; k < 4; k++) begin
      push(k, 8'h10 + 8'(k), 1'b1);
      push(k, 8'h20 + 8'(k), 1'b1);
    end
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    drive();
    wait_drain("t1_drain", 40);

    // Only 0 and 2 requesting: alternate, never ack 1 or 3.
    ack_seen = '0;
    push(0, 8'h30, 1'b1);
    push(0, 8'h31, 1'b1);
    push(2, 8'h32, 1'b1);
    push(2, 8'h33, 1'b1);
    exp_q = '{8'h30, 8'h32, 8'h31, 8'h33};
    drive();
    wait_drain("t2_drain", 40);
    chk("t2_no_ack_1_3", 32'(ack_seen & 4'b1010), 32'd0);
    chk("t2_ack_0_2", 32'(ack_seen), 32'h5);

    // Full backpressure: A5 held for five cycles with no further acks.
    fifo_full_i = 1'b1;
    push(3, 8'hA5, 1'b1);
    push(1, 8'h5A, 1'b1);
    exp_q = '{8'hA5, 8'h5A};
    drive();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_wr", {31'd0, fifo_wr_o}, 32'd1);
      chk("t3_hold_data", 32'(fifo_wdata_bo), 32'hA5);
      chk("t3_hold_ack", 32'(ack_bo), 32'd0);
    end
    fifo_full_i = 1'b0;
    wait_drain("t3_drain", 40);

    // Reset mid-stream while full: held beat discarded, requester 0 first after.
    fifo_full_i = 1'b1;
    push(2, 8'h77, 1'b1);
    drive();
    step();
    step();
    chk("t4_pre_wr", {31'd0, fifo_wr_o}, 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("t4_post_wr", {31'd0, fifo_wr_o}, 32'd0);
    fifo_full_i = 1'b0;
    push(0, 8'h88, 1'b1);
    push(3, 8'h99, 1'b1);
    exp_q = '{8'h88, 8'h99};
    drive();
    wait_drain("t4_drain", 40);

    // Packet of three from requester 1 competing with requester 2.
    push(1, 8'h51, 1'b0);
    push(1, 8'h52, 1'b0);
    push(1, 8'h53, 1'b1);
    push(2, 8'h61, 1'b1);
    push(2, 8'h62, 1'b1);
`ifdef FIFO_ARB_PKTLOCK_EN
    exp_q = '{8'h51, 8'h52, 8'h53, 8'h61, 8'h62};
`else
    exp_q = '{8'h51, 8'h61, 8'h52, 8'h62, 8'h53};
`endif
    drive();
    wait_drain("t5_drain", 40);

    // Random backpressure and packet boundaries; id in data[7:6].
    rand_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 24; s++) begin
        logic [7:0] d;
        d = {2'(k), 6'(s)};
        push(k, d, (s == 23) ? 1'b1 : 1'($urandom_range(0, 1)));
        rexp[k].push_back(d);
      end
    end
    drive();
    for (int i = 0; i < 300; i++) begin
      fifo_full_i = ($urandom_range(0, 2) == 0);
      step();
    end
    fifo_full_i = 1'b0;
    wait_drain("t6_drain", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
